// File: rtl/isl_lock_pkg.sv
// Shared state enum, mode record and width/default constants for the ISL lock sequencer.
package isl_lock_pkg;

  localparam int VTOTAL_W     = 11;
  localparam int PCNT_W       = 20;
  localparam int STABLE_CNT_W = 4;

  localparam int unsigned STABLE_FRAMES_DEF = 4;
  localparam int unsigned PCNT_TOL_DEF      = 16;
  localparam int unsigned WDOG_CYCLES_DEF   = 4194304;

  typedef enum logic [1:0] {
    NOSYNC  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic [VTOTAL_W-1:0] vtotal;
    logic [PCNT_W-1:0]   pcnt;
    logic                interlace;
  } mode_t;

endpackage

// File: rtl/isl_mode_cmp.sv
// Combinational mode compare: exact vtotal/interlace, pixel count within +/-PCNT_TOL.
// Zero latency, no backpressure.
module isl_mode_cmp
  import isl_lock_pkg::*;
#(
  parameter int unsigned PCNT_TOL = PCNT_TOL_DEF
) (
  input  mode_t cur_i,
  input  mode_t ref_i,
  output logic  match_o
);

  localparam logic [PCNT_W:0] TOL_C = (PCNT_W+1)'(PCNT_TOL);

  logic [PCNT_W:0] cur_ext;
  logic [PCNT_W:0] ref_ext;
  logic [PCNT_W:0] abs_diff;

  // One extra bit and an ordered subtract so the difference never wraps.
  always_comb begin
    cur_ext  = {1'b0, cur_i.pcnt};
    ref_ext  = {1'b0, ref_i.pcnt};
    abs_diff = (cur_ext >= ref_ext) ? (cur_ext - ref_ext) : (ref_ext - cur_ext);
    match_o  = (cur_i.vtotal == ref_i.vtotal) &&
               (cur_i.interlace == ref_i.interlace) &&
               (abs_diff <= TOL_C);
  end

endmodule

// File: rtl/isl_lock_sequencer.sv
// Video mode lock sequencer: all outputs registered, one cycle after frame_change_i; no backpressure.
// Optional loss-of-sync watchdog enabled by defining ISL_LOCK_WDOG_EN.
module isl_lock_sequencer
  import isl_lock_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES = STABLE_FRAMES_DEF,
  parameter int unsigned PCNT_TOL      = PCNT_TOL_DEF,
  parameter int unsigned WDOG_CYCLES   = WDOG_CYCLES_DEF
) (
  input  logic                ISL_PCLK_i,
  input  logic                sys_reset_n,
  input  logic                frame_change_i,
  input  logic [VTOTAL_W-1:0] vtotal_i,
  input  logic [PCNT_W-1:0]   pcnt_frame_i,
  input  logic                interlace_i,
  output logic                locked_o,
  output logic                blank_o,
  output logic                resync_strobe_o,
  output logic                mode_change_o,
  output logic [VTOTAL_W-1:0] vtotal_o,
  output logic [PCNT_W-1:0]   pcnt_o,
  output logic                interlace_o
);

  localparam logic [STABLE_CNT_W-1:0] STABLE_C = STABLE_CNT_W'(STABLE_FRAMES);

  if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15 || WDOG_CYCLES < 1) begin : g_param_err
    $error("isl_lock_sequencer: STABLE_FRAMES must be 1..15 and WDOG_CYCLES at least 1");
  end

  lock_state_e              state_q, state_d;
  mode_t                    ref_q, ref_d;
  mode_t                    cur_mode;
  logic [STABLE_CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
  logic                     locked_q, locked_d;
  logic                     blank_q, blank_d;
  logic                     resync_q, resync_d;
  logic                     mode_chg_q, mode_chg_d;
  logic                     match;

  assign cur_mode = {vtotal_i, pcnt_frame_i, interlace_i};

  isl_mode_cmp #(
    .PCNT_TOL (PCNT_TOL)
  ) u_mode_cmp (
    .cur_i   (cur_mode),
    .ref_i   (ref_q),
    .match_o (match)
  );

`ifdef ISL_LOCK_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST_C = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_SAT_C  = WDOG_W'(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_expire;

  always_comb begin
    wdog_d = wdog_q;
    if (frame_change_i) begin
      wdog_d = '0;
    end else if (wdog_q != WDOG_SAT_C) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  // A frame strobe in the expiry cycle wins over the watchdog.
  assign wdog_expire = !frame_change_i && (wdog_q == WDOG_LAST_C);

  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    stable_cnt_d = stable_cnt_q;
    resync_d     = 1'b0;
    mode_chg_d   = 1'b0;

    case (state_q)
      NOSYNC: begin
        if (frame_change_i) begin
          ref_d        = cur_mode;
          stable_cnt_d = '0;
          state_d      = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (frame_change_i) begin
          if (match) begin
            if (stable_cnt_q < STABLE_C) begin
              stable_cnt_d = stable_cnt_q + STABLE_CNT_W'(1);
            end
            if (stable_cnt_d == STABLE_C) begin
              state_d  = LOCKED;
              resync_d = 1'b1;
            end
          end else begin
            ref_d        = cur_mode;
            stable_cnt_d = '0;
            mode_chg_d   = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (frame_change_i && !match) begin
          ref_d        = cur_mode;
          stable_cnt_d = '0;
          mode_chg_d   = 1'b1;
          state_d      = ACQUIRE;
        end
      end
      default: begin
        state_d = NOSYNC;
      end
    endcase

`ifdef ISL_LOCK_WDOG_EN
    if (wdog_expire && (state_q != NOSYNC)) begin
      state_d      = NOSYNC;
      stable_cnt_d = '0;
      resync_d     = 1'b0;
      mode_chg_d   = 1'b1;
    end
`endif

    locked_d = (state_d == LOCKED);
    blank_d  = !locked_d;
  end

  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q      <= NOSYNC;
      ref_q        <= '0;
      stable_cnt_q <= '0;
      locked_q     <= 1'b0;
      blank_q      <= 1'b1;
      resync_q     <= 1'b0;
      mode_chg_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      stable_cnt_q <= stable_cnt_d;
      locked_q     <= locked_d;
      blank_q      <= blank_d;
      resync_q     <= resync_d;
      mode_chg_q   <= mode_chg_d;
    end
  end

  assign locked_o        = locked_q;
  assign blank_o         = blank_q;
  assign resync_strobe_o = resync_q;
  assign mode_change_o   = mode_chg_q;
  assign vtotal_o        = ref_q.vtotal;
  assign pcnt_o          = ref_q.pcnt;
  assign interlace_o     = ref_q.interlace;

endmodule
